// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the memory stage (master)
// and the storage responder (slave).
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A source holds valid and its payload stable until that edge.
// A sink may raise or drop ready freely.
interface dmem_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_we, req_funct3, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_we, req_funct3, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder. One load/store is accepted at a
// time. Byte/half/word lanes are placed little-endian, and loads are sign or
// zero extended. Illegal requests return resp_err after the same latency and
// leave memory untouched.
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_if.slave      bus,
  output logic [1:0] dbg_state
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [AW+1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                  req_err;
  logic [AW-1:0]         idx;
  logic [1:0]            off;
  logic                  commit;
  logic [3:0]            wr_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] ld_data;

  assign idx       = addr_q[AW+1:2];
  assign off       = addr_q[1:0];
  // The response (and any store) lands on the edge that leaves WAIT with the
  // counter exhausted, so LATENCY=1 simply spends zero extra WAIT cycles.
  assign commit    = (state == S_WAIT) && (cnt == '0);
  assign dbg_state = state;

  // Classify the incoming request as legal or rejected.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = bus.req_addr[0];
      3'b010:  req_err = |bus.req_addr[1:0];
      3'b100:  req_err = bus.req_we;
      3'b101:  req_err = bus.req_we | bus.req_addr[0];
      default: req_err = 1'b1;
    endcase
    if (bus.req_addr >= ADDR_LIMIT) req_err = 1'b1;
  end

  // Store lane enables and right-aligned data moved into its byte lanes.
  always_comb begin
    wr_data = wdata_q << {off, 3'b000};
    case (f3_q[1:0])
      2'b00:   wr_be = 4'b0001 << off;
      2'b01:   wr_be = 4'b0011 << off;
      default: wr_be = 4'b1111;
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    rd_word  = mem[idx];
    rd_shift = rd_word >> {off, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{(DATA_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_data = {{(DATA_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, rd_shift[7:0]};
      3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, rd_shift[15:0]};
      default: ld_data = rd_word;
    endcase
  end

  // Storage write: only selected lanes of a legal store, on the commit edge.
  always_ff @(posedge clk) begin
    if (commit && we_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Request/response sequencing with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      we_q           <= 1'b0;
      f3_q           <= 3'b000;
      err_q          <= 1'b0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            addr_q        <= bus.req_addr[AW+1:0];
            wdata_q       <= bus.req_wdata;
            we_q          <= bus.req_we;
            f3_q          <= bus.req_funct3;
            err_q         <= req_err;
            cnt           <= CW'(LATENCY - 1);
            bus.req_ready <= 1'b0;
            state         <= S_WAIT;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= err_q;
            bus.resp_rdata <= (err_q || we_q) ? '0 : ld_data;
            state          <= S_RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.req_ready  <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
